// File: rtl/enemy_bullet_if.sv
// enemy_bullet_if: control, enemy/player position inputs and bullet outputs of the enemy bullet.
interface enemy_bullet_if;
    logic       clk_en;
    logic [1:0] scene;
    logic       enemy_alive;
    logic [8:0] enemy_X;
    logic [8:0] enemy_Y;
    logic [8:0] player_X;
    logic [8:0] X;
    logic [8:0] Y;
    logic       player_hit;
    modport master(output clk_en, scene, enemy_alive, enemy_X, enemy_Y, player_X,
                   input X, Y, player_hit);
    modport slave(input clk_en, scene, enemy_alive, enemy_X, enemy_Y, player_X,
                  output X, Y, player_hit);
endinterface

// File: rtl/enemy_bullet.sv
// enemy_bullet: single falling enemy shot with randomized cooldown and player collision pulse.
// Define ENEMY_BULLET_AIM_EN to make the shot drift one pixel toward the player every second move.
module enemy_bullet #(
    parameter int COOLDOWN   = 60,
    parameter int SPEED      = 2,
    parameter int BOTTOM_Y   = 240,
    parameter int PARK_Y     = 300,
    parameter int X_OFFSET   = 7,
    parameter int Y_OFFSET   = 16,
    parameter int PLAYER_Y   = 215,
    parameter int PLAYER_H   = 16,
    parameter int PLAYER_W   = 16,
    parameter int GAME_SCENE = 1
) (
    input logic          clk,
    input logic          rst_n,
    enemy_bullet_if.slave bus
);
    localparam int CW = $clog2(COOLDOWN + 16);
    typedef enum logic {WAIT, FLY} state_t;
    state_t        state, state_n;
    logic [8:0]    x, x_n, y, y_n;
    logic [CW-1:0] cnt, cnt_n, reload;
    logic          hit, hit_n;
    logic [7:0]    lfsr;
    logic [9:0]    spawn_y, y_next;
    logic          collide;
`ifdef ENEMY_BULLET_AIM_EN
    logic          tog, tog_n;
    logic [8:0]    target;
    assign target = bus.player_X + 9'(X_OFFSET);
`endif
    assign reload  = CW'(COOLDOWN) + CW'(lfsr[3:0]);
    assign spawn_y = {1'b0, bus.enemy_Y} + 10'(Y_OFFSET);
    assign y_next  = {1'b0, y} + 10'(SPEED);
    assign collide = state == FLY
                     && {1'b0, y} >= 10'(PLAYER_Y) && {1'b0, y} < 10'(PLAYER_Y + PLAYER_H)
                     && {1'b0, x} >= {1'b0, bus.player_X}
                     && {1'b0, x} < {1'b0, bus.player_X} + 10'(PLAYER_W);
    assign bus.X          = x;
    assign bus.Y          = y;
    assign bus.player_hit = hit;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WAIT;
            x     <= '0;
            y     <= 9'(PARK_Y);
            cnt   <= CW'(COOLDOWN);
            hit   <= 1'b0;
            lfsr  <= 8'hA5;
`ifdef ENEMY_BULLET_AIM_EN
            tog   <= 1'b0;
`endif
        end else begin
            state <= state_n;
            x     <= x_n;
            y     <= y_n;
            cnt   <= cnt_n;
            hit   <= hit_n;
            lfsr  <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
`ifdef ENEMY_BULLET_AIM_EN
            tog   <= tog_n;
`endif
        end
    end
    always_comb begin
        state_n = state;
        x_n     = x;
        y_n     = y;
        cnt_n   = cnt;
        hit_n   = 1'b0;
`ifdef ENEMY_BULLET_AIM_EN
        tog_n   = tog;
`endif
        if (bus.scene != 2'(GAME_SCENE)) begin
            state_n = WAIT;
            y_n     = 9'(PARK_Y);
            cnt_n   = CW'(COOLDOWN);
        end else if (state == WAIT) begin
            if (bus.clk_en) begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else if (bus.enemy_alive && spawn_y < 10'(BOTTOM_Y)) begin
                    x_n     = bus.enemy_X + 9'(X_OFFSET);
                    y_n     = spawn_y[8:0];
                    state_n = FLY;
`ifdef ENEMY_BULLET_AIM_EN
                    tog_n   = 1'b0;
`endif
                end else if (bus.enemy_alive) begin
                    cnt_n = reload;
                end
            end
        end else if (collide) begin
            hit_n   = 1'b1;
            y_n     = 9'(PARK_Y);
            state_n = WAIT;
            cnt_n   = reload;
        end else if (bus.clk_en) begin
            if (y_next >= 10'(BOTTOM_Y)) begin
                y_n     = 9'(PARK_Y);
                state_n = WAIT;
                cnt_n   = reload;
            end else begin
                y_n = y_next[8:0];
            end
`ifdef ENEMY_BULLET_AIM_EN
            tog_n = ~tog;
            x_n   = !tog ? x : (x < target) ? x + 1'b1 : (x > target) ? x - 1'b1 : x;
`endif
        end
    end
endmodule
